// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the pixel pipeline.
// The generator owns the master side and the pixel pipeline owns the slave side.
interface vga_timing_gen_if #(
    parameter int CW = 11
) ();
    logic          ce;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          vblank;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  ce,
        output hcnt, vcnt, hsync, vsync, de, vblank, line_start, frame_start
    );

    modport slave (
        output ce,
        input  hcnt, vcnt, hsync, vsync, de, vblank, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical counters with
// registered sync, blanking, data-enable and line/frame start decode.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_timing_gen_if.master  tim
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters for CW=%0d", CW);
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          vblank_q, vblank_d;
    logic          line_start_q;
    logic          frame_start_q;

    // Advanced counter position and its decode; only committed when ce is high,
    // so every registered output lines up with the counters it was decoded from.
    // NOTE: combinational logic uses blocking '=' with a default first so no
    // latch is inferred; the clocked block below uses non-blocking '<=' only.
    always_comb begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
        end
        hsync_d  = (hcnt_d >= HS_START && hcnt_d < HS_END) ? HS_POL : ~HS_POL;
        vsync_d  = (vcnt_d >= VS_START && vcnt_d < VS_END) ? VS_POL : ~VS_POL;
        de_d     = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        vblank_d = (vcnt_d >= V_ACT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (tim.ce) begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            vblank_q      <= vblank_d;
            line_start_q  <= (hcnt_d == '0);
            frame_start_q <= (hcnt_d == '0) && (vcnt_d == '0);
        end else begin
            // Levels hold while the pixel enable is low; pulses must not stretch.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign tim.hcnt        = hcnt_q;
    assign tim.vcnt        = vcnt_q;
    assign tim.hsync       = hsync_q;
    assign tim.vsync       = vsync_q;
    assign tim.de          = de_q;
    assign tim.vblank      = vblank_q;
    assign tim.line_start  = line_start_q;
    assign tim.frame_start = frame_start_q;
endmodule
